// File: rtl/debug_scanout.sv
// debug_scanout: snapshots tag status and shifts it out as a 45-bit serial debug frame
module debug_scanout (
    input  logic        debug_clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [11:0] status,
    input  logic [11:0] rx_cmd,
    input  logic        pkt_event,
    output logic        debug_out,
    output logic        frame_active,
    output logic        frame_done
);
    typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, GAP} state_t;
    state_t      state;
    logic [5:0]  k;
    logic [1:0]  g;
    logic [3:0]  seq;
    logic [7:0]  pkt_cnt;
    logic [35:0] snap;
    logic        s1, s2, s3;
    logic [44:0] frame;
    logic        rise, capture;
    assign frame   = {8'hA5, snap, ^snap};
    assign rise    = s2 & ~s3;
    assign capture = (state == IDLE) && scan_en;
    // two-flop synchronizer for pkt_event plus a delay flop for edge detection
    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pkt_event;
            s2 <= s1;
            s3 <= s2;
        end
    end
    // saturating packet counter; an edge landing on the capture cycle belongs to the next frame
    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset)
            pkt_cnt <= 8'd0;
        else if (capture)
            pkt_cnt <= {7'd0, rise};
        else if (rise && pkt_cnt != 8'hFF)
            pkt_cnt <= pkt_cnt + 8'd1;
    end
    // frame sequencer: k is the index of the bit currently on debug_out
    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            k            <= 6'd0;
            g            <= 2'd0;
            seq          <= 4'd0;
            snap         <= 36'd0;
            debug_out    <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    debug_out <= capture;
                    if (capture) begin
                        snap         <= {seq, status, rx_cmd, pkt_cnt};
                        seq          <= seq + 4'd1;
                        k            <= 6'd0;
                        frame_active <= 1'b1;
                        state        <= HDR;
                    end
                end
                HDR, PAY, PAR: begin
                    if (k == 6'd44) begin
                        state        <= GAP;
                        debug_out    <= 1'b0;
                        frame_active <= 1'b0;
                        frame_done   <= 1'b1;
                        g            <= 2'd0;
                    end else begin
                        k         <= k + 6'd1;
                        debug_out <= frame[6'd43 - k];
                        state     <= k < 6'd7 ? HDR : k < 6'd43 ? PAY : PAR;
                    end
                end
                GAP: begin
                    frame_done <= 1'b0;
                    g          <= g + 2'd1;
                    if (g == 2'd3)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/debug_scanout.md
DEBUG_SCANOUT -- requirements
Module: debug_scanout

Interface
REQ-001 debug_clk  input  1  debug shift clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clock debug_clk.
REQ-003 scan_en  input  1  frame request, sampled only in IDLE.
REQ-004 status  input  12  tag status snapshot, bit11..0 = packet_complete, cmd_complete, handlematch, docrc, rx_en, tx_en, bitout, bitclk, rngbitin, rx_overflow, tx_done, txsetupdone.
REQ-005 rx_cmd  input  12  current decoded command word.
REQ-006 pkt_event  input  1  packet_complete from clk domain, asynchronous to debug_clk.
REQ-007 debug_out  output  1  registered serial frame bit.
REQ-008 frame_active  output  1  high while a frame bit is on debug_out.
REQ-009 frame_done  output  1  one-cycle pulse after last frame bit.

Function
REQ-010 Frame SHALL be 45 bits, MSB first per field: header 8'hA5, seq[3:0], status[11:0], rx_cmd[11:0], pkt_cnt[7:0], parity.
REQ-011 Parity bit SHALL be XOR of the 36 bits seq..pkt_cnt (even parity over payload+parity).
REQ-012 States SHALL be IDLE, HDR (8 cycles), PAY (36 cycles), PAR (1 cycle), GAP (4 cycles).
REQ-013 IDLE with scan_en=1 at edge E0: SHALL latch status, rx_cmd, seq, pkt_cnt into a 36-bit snapshot and enter HDR; debug_out = header bit7 after E0.
REQ-014 Frame bit k (0..44) SHALL appear on debug_out after edge E0+k; frame_active=1 exactly for those 45 cycles.
REQ-015 After E45 state SHALL be GAP, debug_out=0, frame_active=0, frame_done=1 for that cycle only.
REQ-016 GAP SHALL last 4 cycles, then IDLE; minimum frame period with scan_en held high = 50 cycles.
REQ-017 scan_en deassertion mid-frame SHALL NOT abort the frame; scan_en is ignored outside IDLE.
REQ-018 In IDLE debug_out SHALL be 0 and snapshot SHALL hold.
REQ-019 seq SHALL increment by 1 at each capture, 4-bit, wrap 15->0; first frame after reset carries seq=0.
REQ-020 pkt_event SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal SHALL increment pkt_cnt.
REQ-021 pkt_cnt SHALL saturate at 255.
REQ-022 pkt_cnt SHALL clear at capture; a synchronized rising edge coincident with capture SHALL leave pkt_cnt=1 (counted in next frame).
REQ-023 status and rx_cmd SHALL be sampled unsynchronized (quasi-static); only the captured copy is shifted.
REQ-024 Snapshot, counters and state SHALL be unaffected by input changes during HDR/PAY/PAR/GAP except pkt_cnt counting.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, debug_out=0, frame_active=0, frame_done=0, seq=0, pkt_cnt=0, synchronizer flops=0, snapshot=0.
REQ-026 reset mid-frame SHALL abort the frame; after release, the next frame starts from header with seq=0.
REQ-027 First capture SHALL be possible at the first debug_clk edge after reset release.

Verification
REQ-028 Reset, scan_en=1 one cycle, status=12'h0A5, rx_cmd=12'h004, no events -> bits 1010_0101, 0000, 0000_1010_0101, 0000_0000_0100, 0000_0000, parity 1; frame_done after E45.
REQ-029 scan_en held high 3 frames -> seq 0,1,2; frame starts at E0, E50, E100; 4 zero gap cycles each.
REQ-030 Three pkt_event pulses (each 4 debug_clk wide) between frames -> next frame pkt_cnt=8'h03, following frame 8'h00.
REQ-031 300 pkt_event pulses before capture -> pkt_cnt=8'hFF; pulse edge on capture cycle -> next frame pkt_cnt=8'h01.
REQ-032 reset asserted at frame bit 20 -> debug_out=0 same cycle; restart yields seq=0 frame.
REQ-033 17 back-to-back frames -> seq wraps 15->0; scan_en dropped at bit 10 -> frame completes all 45 bits.
